qupls4_reservation_station: RTL

- Per-functional-unit reservation station directly downstream of the Qupls4 instruction dispatcher.
- Takes the up-to-four dispatched reservation-station entries each cycle and accepts only those tagged with its own functional-unit id.
- Holds accepted entries until their operands are valid, capturing missing operands by tag match on the writeback buses.
- Issues the oldest ready entry to its functional unit and drives the busy bit the dispatcher samples.

---
 rtl/qupls4_reservation_station.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/qupls4_reservation_station.sv
// Qupls4 per-functional-unit reservation station: accepts dispatched entries for
// one FU, snoops writeback buses for missing operands, issues the oldest ready entry.
package Qupls4_pkg;
  localparam int ROB_ENTRIES = 16;
  localparam int ARGW = 64;
  typedef struct packed {
    logic [3:0]                     funcunit;
    logic [$clog2(ROB_ENTRIES)-1:0] rndx;
    logic [2:0]                     age;
    logic                           argA_v;
    logic                           argB_v;
    logic                           argC_v;
    logic [ARGW-1:0]                argA;
    logic [ARGW-1:0]                argB;
    logic [ARGW-1:0]                argC;
    logic [8:0]                     argD;
    logic [ARGW-1:0]                argI;
  } reservation_station_entry_t;
endpackage

// Operand capture for one entry; the lowest matching bus wins.
module qupls4_rs_wake
  import Qupls4_pkg::*;
#(
  parameter int NWB = 4,
  parameter int WID = 64
) (
  input  reservation_station_entry_t   ent_in,
  input  logic [NWB-1:0]               wb_v,
  input  logic [NWB-1:0][8:0]          wb_tag,
  input  logic [NWB-1:0][WID-1:0]      wb_res,
  output reservation_station_entry_t   ent_out
);
  always_comb begin
    ent_out = ent_in;
    for (int j = NWB-1; j >= 0; j--) begin
      if (wb_v[j] && !ent_in.argA_v && wb_tag[j] == ent_in.argA[8:0]) begin
        ent_out.argA   = ARGW'(wb_res[j]);
        ent_out.argA_v = 1'b1;
      end
      if (wb_v[j] && !ent_in.argB_v && wb_tag[j] == ent_in.argB[8:0]) begin
        ent_out.argB   = ARGW'(wb_res[j]);
        ent_out.argB_v = 1'b1;
      end
      if (wb_v[j] && !ent_in.argC_v && wb_tag[j] == ent_in.argC[8:0]) begin
        ent_out.argC   = ARGW'(wb_res[j]);
        ent_out.argC_v = 1'b1;
      end
    end
  end
endmodule

module qupls4_reservation_station
  import Qupls4_pkg::*;
#(
  parameter logic [3:0] FUNCUNIT = 4'd0,
  parameter int NENTRIES = 4,
  parameter int NWB = 4,
  parameter int WID = 64,
  parameter int ROB_ENTRIES = Qupls4_pkg::ROB_ENTRIES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  reservation_station_entry_t [3:0] rse_i,
  input  logic [3:0]                      rse_v,
  input  logic [ROB_ENTRIES-1:0]          stomp,
  input  logic [NWB-1:0]                  wb_v,
  input  logic [NWB-1:0][8:0]             wb_tag,
  input  logic [NWB-1:0][WID-1:0]         wb_res,
  input  logic                            fu_ready,
  output logic                            busy,
  output logic                            issue_v,
  output reservation_station_entry_t      issue_rse,
  output logic [3:0]                      occupancy,
  output logic                            overflow
);
  localparam int IW = $clog2(NENTRIES);

  reservation_station_entry_t rs_q [NENTRIES];
  reservation_station_entry_t rs_d [NENTRIES];
  reservation_station_entry_t wake_in  [NENTRIES+1];
  reservation_station_entry_t wake_out [NENTRIES+1];
  reservation_station_entry_t arr_ent;
  logic [NENTRIES-1:0] vld, vld_d;
  logic [IW-1:0]       sel, slot;
  logic [2:0]          best_age;
  logic                found, do_issue, arr_hit, multi, slot_ok;
  logic [3:0]          cnt;

  // Slot NENTRIES wakes the arriving entry so a same-cycle writeback is not lost.
  always_comb begin
    for (int i = 0; i < NENTRIES; i++) wake_in[i] = rs_q[i];
    wake_in[NENTRIES] = arr_ent;
  end

  for (genvar g = 0; g <= NENTRIES; g++) begin : g_wake
    qupls4_rs_wake #(.NWB(NWB), .WID(WID)) u_wake (
      .ent_in (wake_in[g]),
      .wb_v   (wb_v),
      .wb_tag (wb_tag),
      .wb_res (wb_res),
      .ent_out(wake_out[g])
    );
  end

  always_comb begin
    found    = 1'b0;
    sel      = '0;
    best_age = '0;
    for (int i = 0; i < NENTRIES; i++)
      if (vld[i] && rs_q[i].argA_v && rs_q[i].argB_v && rs_q[i].argC_v &&
          (!found || rs_q[i].age > best_age)) begin
        found    = 1'b1;
        sel      = IW'(i);
        best_age = rs_q[i].age;
      end
  end

  assign do_issue = fu_ready && found && !stomp[rs_q[sel].rndx];

  // Stomped arrivals are filtered before winner selection so they never count as overflow.
  always_comb begin
    arr_hit = 1'b0;
    multi   = 1'b0;
    arr_ent = rse_i[0];
    for (int k = 0; k < 4; k++)
      if (rse_v[k] && rse_i[k].funcunit == FUNCUNIT && !stomp[rse_i[k].rndx]) begin
        if (arr_hit) multi = 1'b1;
        else begin
          arr_hit = 1'b1;
          arr_ent = rse_i[k];
        end
      end
  end

  always_comb begin
    slot_ok = 1'b0;
    slot    = '0;
    for (int i = NENTRIES-1; i >= 0; i--)
      if (!vld[i] || (do_issue && sel == IW'(i))) begin
        slot_ok = 1'b1;
        slot    = IW'(i);
      end
  end

  always_comb begin
    vld_d = '0;
    cnt   = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      rs_d[i] = wake_out[i];
      if (rs_d[i].age != 3'd7) rs_d[i].age = rs_d[i].age + 3'd1;
      vld_d[i] = vld[i] && !stomp[rs_q[i].rndx] && !(do_issue && sel == IW'(i));
    end
    if (arr_hit && slot_ok) begin
      rs_d[slot]     = wake_out[NENTRIES];
      rs_d[slot].age = 3'd0;
      vld_d[slot]    = 1'b1;
    end
    for (int i = 0; i < NENTRIES; i++) cnt = cnt + 4'(vld_d[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld       <= '0;
      for (int i = 0; i < NENTRIES; i++) rs_q[i] <= '0;
      issue_v   <= 1'b0;
      issue_rse <= '0;
      occupancy <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      vld       <= vld_d;
      for (int i = 0; i < NENTRIES; i++) rs_q[i] <= rs_d[i];
      issue_v   <= do_issue;
      if (do_issue) issue_rse <= rs_q[sel];
      occupancy <= cnt;
      busy      <= cnt >= 4'(NENTRIES-1);
      overflow  <= overflow | multi | (arr_hit && !slot_ok);
    end
  end
endmodule
